// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch and loader/debug share one fixed-latency memory port.
// Round-robin between the two requesters, with a loader lock that starves fetch.
module imem_arbiter #(
  parameter int LAT   = 1,
  parameter int IDX_W = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_en,
  input  logic [IDX_W-1:0] f_index,
  output logic             f_gnt,
  output logic [31:0]      f_rdata,
  output logic             f_rvalid,
  input  logic             l_req,
  input  logic             l_we,
  input  logic [IDX_W-1:0] l_index,
  input  logic [31:0]      l_wdata,
  input  logic             l_lock,
  output logic             l_gnt,
  output logic [31:0]      l_rdata,
  output logic             l_rvalid,
  output logic             m_en,
  output logic             m_we,
  output logic [IDX_W-1:0] m_index,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata
);

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_L = 1'b1;

  logic             last_q, last_d;
  logic             m_en_q, m_en_d;
  logic             m_we_q, m_we_d;
  logic [IDX_W-1:0] m_index_q, m_index_d;
  logic [31:0]      m_wdata_q, m_wdata_d;
  logic             m_own_q, m_own_d;
  logic [LAT-1:0]   tag_v_q, tag_v_d;
  logic [LAT-1:0]   tag_o_q, tag_o_d;

  // Grant decision; fetch wins a contested cycle only if the loader went last.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst_n) begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
    end else if (f_en && !l_lock && (!l_req || (last_q == OWN_L))) begin
      f_gnt = 1'b1;
    end else if (l_req) begin
      l_gnt = 1'b1;
    end else begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
    end
  end

  // Memory request stage and response tag pipeline.
  always_comb begin
    last_d    = last_q;
    m_en_d    = 1'b0;
    m_we_d    = 1'b0;
    m_index_d = m_index_q;
    m_wdata_d = m_wdata_q;
    m_own_d   = m_own_q;
    if (f_gnt) begin
      m_en_d    = 1'b1;
      m_index_d = f_index;
      m_own_d   = OWN_F;
      last_d    = OWN_F;
    end else if (l_gnt) begin
      m_en_d    = 1'b1;
      m_we_d    = l_we;
      m_index_d = l_index;
      m_wdata_d = l_wdata;
      m_own_d   = OWN_L;
      last_d    = OWN_L;
    end else begin
      m_en_d = 1'b0;
    end
    // The tag enters alongside the issued access, so the last entry lines up with m_rdata.
    tag_v_d    = tag_v_q;
    tag_o_d    = tag_o_q;
    tag_v_d[0] = m_en_q & ~m_we_q;
    tag_o_d[0] = m_own_q;
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_o_d[i] = tag_o_q[i-1];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= OWN_L;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_index_q <= {IDX_W{1'b0}};
      m_wdata_q <= 32'h0000_0000;
      m_own_q   <= OWN_F;
      tag_v_q   <= {LAT{1'b0}};
      tag_o_q   <= {LAT{1'b0}};
    end else begin
      last_q    <= last_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_index_q <= m_index_d;
      m_wdata_q <= m_wdata_d;
      m_own_q   <= m_own_d;
      tag_v_q   <= tag_v_d;
      tag_o_q   <= tag_o_d;
    end
  end

  assign m_en     = m_en_q;
  assign m_we     = m_we_q;
  assign m_index  = m_index_q;
  assign m_wdata  = m_wdata_q;
  assign f_rvalid = tag_v_q[LAT-1] & (tag_o_q[LAT-1] == OWN_F);
  assign l_rvalid = tag_v_q[LAT-1] & (tag_o_q[LAT-1] == OWN_L);
  assign f_rdata  = m_rdata;
  assign l_rdata  = m_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: LAT=1 and LAT=3 instances share stimulus; a transaction-level
// model (grant rules, reference memory, response schedule) is compared every cycle.
module tb_imem_arbiter;

  localparam int NI = 2;
  localparam int NC = 4096;
  localparam int SEL_FG = 0, SEL_LG = 1, SEL_MEN = 2, SEL_MWE = 3, SEL_MIDX = 4;
  localparam int SEL_FRV = 5, SEL_LRV = 6, SEL_FRD = 7, SEL_LRD = 8;

  logic        clk = 1'b0;
  logic        rst_n, f_en, l_req, l_we, l_lock;
  logic [29:0] f_index, l_index;
  logic [31:0] l_wdata;

  logic        f_gnt_s [NI];
  logic        l_gnt_s [NI];
  logic        f_rvalid_s [NI];
  logic        l_rvalid_s [NI];
  logic        m_en_s [NI];
  logic        m_we_s [NI];
  logic [29:0] m_index_s [NI];
  logic [31:0] f_rdata_s [NI];
  logic [31:0] l_rdata_s [NI];
  logic [31:0] m_wdata_s [NI];
  logic [31:0] m_rdata_s [NI];

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < NI; k++) begin : g_inst
      localparam int L = (k == 0) ? 1 : 3;
      logic [31:0] mem [256];
      logic [31:0] pipe [L];

      imem_arbiter #(.LAT(L), .IDX_W(30)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .f_en(f_en), .f_index(f_index), .f_gnt(f_gnt_s[k]),
        .f_rdata(f_rdata_s[k]), .f_rvalid(f_rvalid_s[k]),
        .l_req(l_req), .l_we(l_we), .l_index(l_index), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt_s[k]),
        .l_rdata(l_rdata_s[k]), .l_rvalid(l_rvalid_s[k]),
        .m_en(m_en_s[k]), .m_we(m_we_s[k]), .m_index(m_index_s[k]),
        .m_wdata(m_wdata_s[k]), .m_rdata(m_rdata_s[k])
      );

      initial for (int i = 0; i < 256; i++) mem[i] <= 32'(i) + 32'd3;

      // Fixed-latency memory: a read issued in cycle c returns data in cycle c+L.
      always @(posedge clk) begin
        if (m_en_s[k] && m_we_s[k]) mem[m_index_s[k][7:0]] <= m_wdata_s[k];
        pipe[0] <= (m_en_s[k] && !m_we_s[k]) ? mem[m_index_s[k][7:0]] : 32'h0;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign m_rdata_s[k] = pipe[L-1];
    end
  endgenerate

  typedef struct {int cyc; int inst; int sel; logic [31:0] val;} lit_t;
  lit_t lits [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit          last_l [NI];
  logic        exp_en [NI];
  logic        exp_we [NI];
  logic [29:0] exp_idx [NI];
  logic [31:0] exp_wd [NI];
  logic [31:0] ref_mem [NI][256];
  bit          resp_v [NI][NC];
  bit          resp_o [NI][NC];
  logic [31:0] resp_d [NI][NC];

  initial for (int k = 0; k < NI; k++) for (int i = 0; i < 256; i++) ref_mem[k][i] = 32'(i) + 32'd3;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] get_sig(input int k, input int sel);
    case (sel)
      SEL_FG:   return 32'(f_gnt_s[k]);
      SEL_LG:   return 32'(l_gnt_s[k]);
      SEL_MEN:  return 32'(m_en_s[k]);
      SEL_MWE:  return 32'(m_we_s[k]);
      SEL_MIDX: return 32'(m_index_s[k]);
      SEL_FRV:  return 32'(f_rvalid_s[k]);
      SEL_LRV:  return 32'(l_rvalid_s[k]);
      SEL_FRD:  return f_rdata_s[k];
      default:  return l_rdata_s[k];
    endcase
  endfunction

  task automatic expect_at(input int c, input int k, input int sel, input logic [31:0] v);
    lit_t e;
    e.cyc = c; e.inst = k; e.sel = sel; e.val = v;
    lits.push_back(e);
  endtask

  // Per-cycle comparison against the transaction model, plus the pinned literals.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      int lat;
      bit fg, lg;
      lat = (k == 0) ? 1 : 3;
      if (!rst_n) begin
        chk("f_gnt_rst", k, 32'(f_gnt_s[k]), 32'd0);
        chk("l_gnt_rst", k, 32'(l_gnt_s[k]), 32'd0);
        chk("m_en_rst", k, 32'(m_en_s[k]), 32'd0);
        chk("m_index_rst", k, 32'(m_index_s[k]), 32'd0);
        chk("m_wdata_rst", k, m_wdata_s[k], 32'd0);
        chk("rvalid_rst", k, 32'(f_rvalid_s[k] | l_rvalid_s[k]), 32'd0);
        last_l[k] = 1'b1;
        exp_en[k] = 1'b0; exp_we[k] = 1'b0; exp_idx[k] = 30'd0; exp_wd[k] = 32'd0;
        for (int c = cyc; c < NC; c++) resp_v[k][c] = 1'b0;
      end else begin
        chk("m_en", k, 32'(m_en_s[k]), 32'(exp_en[k]));
        chk("m_we", k, 32'(m_we_s[k]), 32'(exp_we[k]));
        chk("m_index", k, 32'(m_index_s[k]), 32'(exp_idx[k]));
        chk("m_wdata", k, m_wdata_s[k], exp_wd[k]);
        chk("f_rvalid", k, 32'(f_rvalid_s[k]), 32'(resp_v[k][cyc] && !resp_o[k][cyc]));
        chk("l_rvalid", k, 32'(l_rvalid_s[k]), 32'(resp_v[k][cyc] && resp_o[k][cyc]));
        if (resp_v[k][cyc] && !resp_o[k][cyc]) chk("f_rdata", k, f_rdata_s[k], resp_d[k][cyc]);
        if (resp_v[k][cyc] && resp_o[k][cyc])  chk("l_rdata", k, l_rdata_s[k], resp_d[k][cyc]);
        fg = f_en && !l_lock && (!l_req || last_l[k]);
        lg = l_req && !fg;
        chk("f_gnt", k, 32'(f_gnt_s[k]), 32'(fg));
        chk("l_gnt", k, 32'(l_gnt_s[k]), 32'(lg));
        exp_en[k] = fg || lg;
        exp_we[k] = 1'b0;
        if (fg) begin
          exp_idx[k] = f_index;
          resp_v[k][cyc+1+lat] = 1'b1;
          resp_o[k][cyc+1+lat] = 1'b0;
          resp_d[k][cyc+1+lat] = ref_mem[k][f_index[7:0]];
          last_l[k] = 1'b0;
        end else if (lg) begin
          exp_we[k]  = l_we;
          exp_idx[k] = l_index;
          exp_wd[k]  = l_wdata;
          if (l_we) ref_mem[k][l_index[7:0]] = l_wdata;
          else begin
            resp_v[k][cyc+1+lat] = 1'b1;
            resp_o[k][cyc+1+lat] = 1'b1;
            resp_d[k][cyc+1+lat] = ref_mem[k][l_index[7:0]];
          end
          last_l[k] = 1'b1;
        end
      end
    end
    foreach (lits[j]) begin
      if (lits[j].cyc == cyc)
        chk($sformatf("lit_sel%0d", lits[j].sel), lits[j].inst, get_sig(lits[j].inst, lits[j].sel), lits[j].val);
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int c;

  initial begin
    rst_n = 1'b0; f_en = 1'b1; l_req = 1'b1; l_we = 1'b0; l_lock = 1'b0;
    f_index = 30'd0; l_index = 30'd0; l_wdata = 32'd0;
    repeat (3) step();
    // Requests held through reset must not be granted.
    expect_at(cyc, 0, SEL_FG, 32'd0);
    expect_at(cyc, 0, SEL_LG, 32'd0);
    expect_at(cyc, 1, SEL_MEN, 32'd0);
    f_index = 30'h31; l_index = 30'h32;
    step();
    rst_n = 1'b1;
    c = cyc;
    expect_at(c,   0, SEL_FG, 32'd1);
    expect_at(c+1, 0, SEL_LG, 32'd1);
    expect_at(c+2, 0, SEL_FG, 32'd1);
    expect_at(c+3, 0, SEL_LG, 32'd1);
    expect_at(c+1, 0, SEL_MIDX, 32'h31);
    expect_at(c+2, 0, SEL_MIDX, 32'h32);
    expect_at(c+2, 0, SEL_FRV, 32'd1);
    expect_at(c+2, 0, SEL_FRD, 32'h34);
    expect_at(c+3, 0, SEL_LRV, 32'd1);
    expect_at(c+3, 0, SEL_LRD, 32'h35);
    repeat (4) step();
    f_en = 1'b0; l_req = 1'b0;
    repeat (2) step();

    // Lone fetch read of 0x10.
    c = cyc;
    f_en = 1'b1; f_index = 30'h10;
    expect_at(c,   0, SEL_FG, 32'd1);
    expect_at(c+1, 0, SEL_MEN, 32'd1);
    expect_at(c+1, 0, SEL_MIDX, 32'h10);
    expect_at(c+1, 0, SEL_LRV, 32'd0);
    expect_at(c+2, 0, SEL_FRV, 32'd1);
    expect_at(c+2, 0, SEL_FRD, 32'h13);
    expect_at(c+2, 0, SEL_LRV, 32'd0);
    step();
    f_en = 1'b0;
    repeat (4) step();

    // Locked loader write while fetch waits.
    c = cyc;
    l_lock = 1'b1; f_en = 1'b1; f_index = 30'h11;
    l_req = 1'b1; l_we = 1'b1; l_index = 30'h4; l_wdata = 32'hDEAD_BEEF;
    expect_at(c,   0, SEL_LG, 32'd1);
    expect_at(c,   0, SEL_FG, 32'd0);
    expect_at(c+1, 0, SEL_MEN, 32'd1);
    expect_at(c+1, 0, SEL_MWE, 32'd1);
    expect_at(c+1, 0, SEL_FG, 32'd0);
    expect_at(c+2, 0, SEL_FG, 32'd0);
    expect_at(c+2, 0, SEL_FRV, 32'd0);
    expect_at(c+2, 0, SEL_LRV, 32'd0);
    expect_at(c+3, 0, SEL_FG, 32'd1);
    step();
    l_req = 1'b0; l_we = 1'b0;
    repeat (2) step();
    l_lock = 1'b0;
    step();
    f_en = 1'b0;
    repeat (4) step();

    // Three back-to-back fetches on the LAT=3 instance.
    c = cyc;
    f_en = 1'b1; f_index = 30'd1;
    expect_at(c+3, 1, SEL_FRV, 32'd0);
    expect_at(c+4, 1, SEL_FRV, 32'd1);
    expect_at(c+4, 1, SEL_FRD, 32'd4);
    expect_at(c+5, 1, SEL_FRV, 32'd1);
    expect_at(c+5, 1, SEL_FRD, 32'd5);
    expect_at(c+6, 1, SEL_FRV, 32'd1);
    expect_at(c+6, 1, SEL_FRD, 32'd6);
    expect_at(c+7, 1, SEL_FRV, 32'd0);
    step();
    f_index = 30'd2;
    step();
    f_index = 30'd3;
    step();
    f_en = 1'b0;
    repeat (6) step();

    // Reset one cycle after a read grant kills the read.
    c = cyc;
    f_en = 1'b1; f_index = 30'h20;
    expect_at(c+1, 0, SEL_MEN, 32'd0);
    expect_at(c+1, 1, SEL_MEN, 32'd0);
    expect_at(c+2, 0, SEL_FRV, 32'd0);
    expect_at(c+4, 1, SEL_FRV, 32'd0);
    step();
    f_en = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();

    // Loader write then fetch read of the same index.
    c = cyc;
    l_req = 1'b1; l_we = 1'b1; l_index = 30'h8; l_wdata = 32'hCAFE_F00D;
    expect_at(c,   0, SEL_LG, 32'd1);
    expect_at(c+1, 0, SEL_FG, 32'd1);
    expect_at(c+1, 0, SEL_MWE, 32'd1);
    expect_at(c+1, 0, SEL_MIDX, 32'h8);
    expect_at(c+2, 0, SEL_MWE, 32'd0);
    expect_at(c+3, 0, SEL_FRV, 32'd1);
    expect_at(c+3, 0, SEL_FRD, 32'hCAFE_F00D);
    expect_at(c+5, 1, SEL_FRV, 32'd1);
    expect_at(c+5, 1, SEL_FRD, 32'hCAFE_F00D);
    step();
    l_req = 1'b0; l_we = 1'b0; f_en = 1'b1; f_index = 30'h8;
    step();
    f_en = 1'b0;
    repeat (6) step();

    // Mixed traffic table, checked by the model alone.
    for (int i = 0; i < 32; i++) begin
      f_en    = i[0] | i[2];
      l_req   = i[1];
      l_we    = i[3];
      l_lock  = ((i % 7) == 5);
      f_index = 30'(i + 64);
      l_index = 30'(i + 96);
      l_wdata = 32'hA500_0000 + 32'(i);
      step();
    end
    f_en = 1'b0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
